a8_host_master: RTL and testbench

//  Bus-cycle initiator for the A8 expansion bus: generates a8_clk (~1.79 MHz) from
//  clk200 and issues 6502-style read/write cycles with the standard 558 ns timing.

---
 rtl/a8_host_master_pkg.sv | 29 ++
 rtl/a8_host_master_if.sv | 33 +++
 rtl/a8_cycle_timer.sv | 48 ++++
 rtl/a8_host_master.sv | 100 ++++++++++
 tb/tb_a8_host_master.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/a8_host_master_pkg.sv
// Shared A8 bus timing constants and cycle-register type.
// The bus monitor imports the same constants, so both ends of the bus agree on timing.
package a8_host_master_pkg;

    localparam int          A8_CYCLE_TICKS = 112;
    localparam int          A8_HIGH_TICK   = 56;
    localparam int          A8_ADDR_TICK   = 35;
    localparam int          A8_WRITE_TICK  = 84;
    localparam int          A8_SAMPLE_TICK = 97;
    localparam int          A8_HOLD_TICKS  = 2;
    localparam logic [15:0] A8_IDLE_ADDR   = 16'hFFFF;

    typedef struct packed {
        logic        active;
        logic        rw_n;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } a8_cycle_t;

    // Every strobe must land strictly inside one bus cycle, in bus order.
    function automatic bit a8_timing_ok(input int cycle_ticks, input int high_tick,
                                        input int addr_tick, input int write_tick,
                                        input int sample_tick, input int hold_ticks);
        return (addr_tick < high_tick) && (high_tick < write_tick) &&
               (write_tick < sample_tick) && (sample_tick < cycle_ticks - 1) &&
               (hold_ticks >= 1) && (hold_ticks < addr_tick);
    endfunction

endpackage

// File: rtl/a8_host_master_if.sv
// Request/response and A8 bus signals of the host master.
// The master modport is the initiator; the slave modport is the rig or bench side.
interface a8_host_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_rw_n;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_rw_n;
    logic [7:0]  rsp_rdata;
    logic        a8_halt_n;
    logic        a8_clk;
    logic [15:0] a8_addr;
    logic        a8_rw_n;
    logic [7:0]  a8_data_out;
    logic        a8_data_oe;
    logic [7:0]  a8_data_in;

    modport master (
        input  req_valid, req_rw_n, req_addr, req_wdata, a8_halt_n, a8_data_in,
        output req_ready, rsp_valid, rsp_rw_n, rsp_rdata,
               a8_clk, a8_addr, a8_rw_n, a8_data_out, a8_data_oe
    );

    modport slave (
        output req_valid, req_rw_n, req_addr, req_wdata, a8_halt_n, a8_data_in,
        input  req_ready, rsp_valid, rsp_rw_n, rsp_rdata,
               a8_clk, a8_addr, a8_rw_n, a8_data_out, a8_data_oe
    );

endinterface

// File: rtl/a8_cycle_timer.sv
// Bus-cycle tick counter and phi2 generator.
// Strobes fire one tick early, so registers loaded on them change exactly at the named tick.
module a8_cycle_timer
    import a8_host_master_pkg::*;
#(
    parameter int CYCLE_TICKS = A8_CYCLE_TICKS,
    parameter int HIGH_TICK   = A8_HIGH_TICK,
    parameter int ADDR_TICK   = A8_ADDR_TICK,
    parameter int WRITE_TICK  = A8_WRITE_TICK,
    parameter int SAMPLE_TICK = A8_SAMPLE_TICK,
    parameter int HOLD_TICKS  = A8_HOLD_TICKS
) (
    input  logic clk200,
    input  logic a8_rst_n,
    output logic a8_clk,
    output logic end_of_cycle,
    output logic addr_strobe,
    output logic write_strobe,
    output logic sample_strobe,
    output logic hold_end
);

    localparam int TW = $clog2(CYCLE_TICKS);

    logic [TW-1:0] ticks;
    logic [TW-1:0] ticks_nxt;

    assign end_of_cycle  = (ticks == TW'(CYCLE_TICKS - 1));
    assign addr_strobe   = (ticks == TW'(ADDR_TICK - 1));
    assign write_strobe  = (ticks == TW'(WRITE_TICK - 1));
    // Read data is captured at the end of SAMPLE_TICK itself.
    assign sample_strobe = (ticks == TW'(SAMPLE_TICK));
    assign hold_end      = (ticks == TW'(HOLD_TICKS - 1));

    assign ticks_nxt = end_of_cycle ? '0 : ticks + TW'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk200 or negedge a8_rst_n) begin
        if (!a8_rst_n) begin
            ticks  <= '0;
            a8_clk <= 1'b0;
        end else begin
            ticks  <= ticks_nxt;
            a8_clk <= (ticks_nxt >= TW'(HIGH_TICK));
        end
    end

endmodule

// File: rtl/a8_host_master.sv
// A8 expansion-bus cycle initiator: one request per bus cycle, 6502-style timing.
// A request accepted at the last tick of cycle N runs on the bus in cycle N+1.
module a8_host_master
    import a8_host_master_pkg::*;
#(
    parameter int          CYCLE_TICKS = A8_CYCLE_TICKS,
    parameter int          HIGH_TICK   = A8_HIGH_TICK,
    parameter int          ADDR_TICK   = A8_ADDR_TICK,
    parameter int          WRITE_TICK  = A8_WRITE_TICK,
    parameter int          SAMPLE_TICK = A8_SAMPLE_TICK,
    parameter int          HOLD_TICKS  = A8_HOLD_TICKS,
    parameter logic [15:0] IDLE_ADDR   = A8_IDLE_ADDR
) (
    input  logic             clk200,
    input  logic             a8_rst_n,
    a8_host_master_if.master bus
);

    if (!a8_timing_ok(CYCLE_TICKS, HIGH_TICK, ADDR_TICK, WRITE_TICK, SAMPLE_TICK, HOLD_TICKS))
    begin : g_bad_timing
        $error("a8_host_master: tick parameters are not in bus order");
    end

    localparam a8_cycle_t IDLE_CYCLE = '{active: 1'b0, rw_n: 1'b1, addr: IDLE_ADDR, wdata: 8'h00};

    logic      end_of_cycle;
    logic      addr_strobe;
    logic      write_strobe;
    logic      sample_strobe;
    logic      hold_end;
    a8_cycle_t cyc;

    a8_cycle_timer #(
        .CYCLE_TICKS (CYCLE_TICKS),
        .HIGH_TICK   (HIGH_TICK),
        .ADDR_TICK   (ADDR_TICK),
        .WRITE_TICK  (WRITE_TICK),
        .SAMPLE_TICK (SAMPLE_TICK),
        .HOLD_TICKS  (HOLD_TICKS)
    ) u_timer (
        .clk200        (clk200),
        .a8_rst_n      (a8_rst_n),
        .a8_clk        (bus.a8_clk),
        .end_of_cycle  (end_of_cycle),
        .addr_strobe   (addr_strobe),
        .write_strobe  (write_strobe),
        .sample_strobe (sample_strobe),
        .hold_end      (hold_end)
    );

    // A halted host takes nothing, so the following cycle falls back to an idle read.
    assign bus.req_ready = end_of_cycle & bus.a8_halt_n;

    always_ff @(posedge clk200 or negedge a8_rst_n) begin
        if (!a8_rst_n) begin
            cyc <= IDLE_CYCLE;
        end else if (end_of_cycle) begin
            if (bus.req_valid && bus.req_ready) begin
                cyc <= '{active: 1'b1, rw_n: bus.req_rw_n, addr: bus.req_addr, wdata: bus.req_wdata};
            end else begin
                cyc <= IDLE_CYCLE;
            end
        end
    end

    always_ff @(posedge clk200 or negedge a8_rst_n) begin
        if (!a8_rst_n) begin
            bus.a8_addr     <= IDLE_ADDR;
            bus.a8_rw_n     <= 1'b1;
            bus.a8_data_out <= 8'h00;
            bus.a8_data_oe  <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rw_n    <= 1'b1;
            bus.rsp_rdata   <= 8'h00;
        end else begin
            // Address and R/W keep the previous cycle's values until ADDR_TICK.
            if (addr_strobe) begin
                bus.a8_addr <= cyc.addr;
                bus.a8_rw_n <= cyc.rw_n;
            end

            // Write data is held across the phi2 falling edge for HOLD_TICKS ticks.
            if (write_strobe && cyc.active && !cyc.rw_n) begin
                bus.a8_data_out <= cyc.wdata;
                bus.a8_data_oe  <= 1'b1;
            end else if (hold_end) begin
                bus.a8_data_oe  <= 1'b0;
            end

            bus.rsp_valid <= sample_strobe && cyc.active;
            if (sample_strobe && cyc.active) begin
                bus.rsp_rw_n <= cyc.rw_n;
                if (cyc.rw_n) begin
                    bus.rsp_rdata <= bus.a8_data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_a8_host_master.sv
// Self-checking bench for a8_host_master: directed bus scenarios plus randomized traffic,
// compared every tick against a per-cycle transaction model (current / previous bus cycle).
module tb_a8_host_master;

    import a8_host_master_pkg::*;

    localparam int CT     = A8_CYCLE_TICKS;
    localparam int HIGH   = A8_HIGH_TICK;
    localparam int ADDR   = A8_ADDR_TICK;
    localparam int WRITE  = A8_WRITE_TICK;
    localparam int SAMPLE = A8_SAMPLE_TICK;
    localparam int HOLD   = A8_HOLD_TICKS;

    typedef struct {
        bit        active;
        bit        rw_n;
        bit [15:0] addr;
        bit [7:0]  wdata;
        bit [7:0]  rdata;
    } txn_t;

    localparam txn_t IDLE_TXN = '{active: 1'b0, rw_n: 1'b1, addr: 16'hFFFF, wdata: 8'h00, rdata: 8'h00};

    logic clk200   = 1'b0;
    logic a8_rst_n = 1'b0;

    a8_host_master_if bus ();

    a8_host_master dut (
        .clk200   (clk200),
        .a8_rst_n (a8_rst_n),
        .bus      (bus)
    );

    always #5 clk200 = ~clk200;

    txn_t     req_q[$];
    txn_t     cur;
    txn_t     prev;
    txn_t     nxt;
    int       tick_abs;
    int       n_checks;
    int       n_errors;
    int       rsp_seen;
    bit       halt_n;
    bit       force_en;
    bit [7:0] force_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (tick %0d, t=%0t)", tag, got, exp, tick_abs % CT, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a8_clk"},    bus.a8_clk,      32'h0);
        check({tag, "_a8_addr"},   bus.a8_addr,     32'hFFFF);
        check({tag, "_a8_rw_n"},   bus.a8_rw_n,     32'h1);
        check({tag, "_data_oe"},   bus.a8_data_oe,  32'h0);
        check({tag, "_data_out"},  bus.a8_data_out, 32'h0);
        check({tag, "_req_ready"}, bus.req_ready,   32'h0);
        check({tag, "_rsp_valid"}, bus.rsp_valid,   32'h0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata,   32'h0);
    endtask

    // One clk200 tick: drive inputs mid-tick, compare outputs with the model, advance the model.
    task automatic step(input bit wait_edge);
        int       phase;
        bit [7:0] din;
        bit       exp_oe;
        if (wait_edge) @(negedge clk200);
        phase = tick_abs % CT;
        if (phase == 0) begin
            prev = cur;
            cur  = nxt;
            nxt  = IDLE_TXN;
        end

        bus.a8_halt_n = halt_n;
        if (req_q.size() > 0) begin
            bus.req_valid = 1'b1;
            bus.req_rw_n  = req_q[0].rw_n;
            bus.req_addr  = req_q[0].addr;
            bus.req_wdata = req_q[0].wdata;
        end else begin
            bus.req_valid = 1'b0;
            bus.req_rw_n  = 1'($urandom);
            bus.req_addr  = 16'($urandom);
            bus.req_wdata = 8'($urandom);
        end
        din = (force_en && phase == SAMPLE) ? force_val : 8'($urandom);
        bus.a8_data_in = din;
        if (phase == SAMPLE) cur.rdata = din;
        #1;

        exp_oe = (cur.active && !cur.rw_n && phase >= WRITE) ||
                 (prev.active && !prev.rw_n && phase < HOLD);
        check("a8_clk",    bus.a8_clk,     32'(phase >= HIGH));
        check("a8_addr",   bus.a8_addr,    32'((phase >= ADDR) ? cur.addr : prev.addr));
        check("a8_rw_n",   bus.a8_rw_n,    32'((phase >= ADDR) ? cur.rw_n : prev.rw_n));
        check("a8_data_oe", bus.a8_data_oe, 32'(exp_oe));
        if (exp_oe)
            check("a8_data_out", bus.a8_data_out, 32'((phase >= WRITE) ? cur.wdata : prev.wdata));
        check("req_ready", bus.req_ready, 32'(phase == CT - 1 && halt_n));
        check("rsp_valid", bus.rsp_valid, 32'(cur.active && phase == SAMPLE + 1));
        if (cur.active && phase == SAMPLE + 1) begin
            check("rsp_rw_n", bus.rsp_rw_n, 32'(cur.rw_n));
            if (cur.rw_n) check("rsp_rdata", bus.rsp_rdata, 32'(cur.rdata));
        end
        if (bus.rsp_valid === 1'b1) rsp_seen++;

        if (phase == CT - 1 && halt_n && req_q.size() > 0) begin
            nxt        = req_q.pop_front();
            nxt.active = 1'b1;
        end
        tick_abs++;
    endtask

    task automatic run_cycles(input int n);
        repeat (n * CT) step(1'b1);
    endtask

    task automatic run_to_phase(input int p);
        while (tick_abs % CT != p) step(1'b1);
    endtask

    task automatic apply_reset(input int hold_ticks);
        @(negedge clk200);
        a8_rst_n = 1'b0;
        #1;
        check_reset_state("rst");
        repeat (hold_ticks) begin
            @(negedge clk200);
            check("rst_hold_rsp_valid", bus.rsp_valid, 32'h0);
            check("rst_hold_data_oe",   bus.a8_data_oe, 32'h0);
        end
        @(negedge clk200);
        a8_rst_n = 1'b1;
        tick_abs = 0;
        cur      = IDLE_TXN;
        prev     = IDLE_TXN;
        nxt      = IDLE_TXN;
        req_q.delete();
        step(1'b0);
    endtask

    task automatic push(input bit rw_n, input bit [15:0] addr, input bit [7:0] wdata);
        req_q.push_back('{active: 1'b1, rw_n: rw_n, addr: addr, wdata: wdata, rdata: 8'h00});
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        halt_n        = 1'b1;
        force_en      = 1'b0;
        force_val     = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_rw_n  = 1'b1;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 8'h00;
        bus.a8_halt_n = 1'b1;
        bus.a8_data_in = 8'h00;

        // Idle after reset: FFFF reads, phi2 56/56, no data drive, no responses.
        apply_reset(20);
        rsp_seen = 0;
        run_cycles(3);
        check("idle_rsp_count", rsp_seen, 32'd0);

        // Single write, then single read with known data on the bus at SAMPLE_TICK.
        push(1'b0, 16'hD605, 8'h5A);
        run_cycles(3);
        force_en  = 1'b1;
        force_val = 8'hC3;
        push(1'b1, 16'hD700, 8'h00);
        run_cycles(3);
        force_en = 1'b0;
        check("read_d700_rdata", bus.rsp_rdata, 32'hC3);

        // Three back-to-back writes with req_valid held.
        run_to_phase(0);
        rsp_seen = 0;
        push(1'b0, 16'hD400, 8'h11);
        push(1'b0, 16'hD401, 8'h22);
        push(1'b0, 16'hD402, 8'h33);
        run_cycles(5);
        check("b2b_rsp_count", rsp_seen, 32'd3);
        check("b2b_queue_drained", req_q.size(), 32'd0);

        // Halt sampled at the last tick with a request pending.
        run_to_phase(CT - 1);
        push(1'b0, 16'hD301, 8'hA5);
        halt_n = 1'b0;
        step(1'b1);
        halt_n = 1'b1;
        check("halt_request_still_pending", req_q.size(), 32'd1);
        run_cycles(3);

        // Randomized traffic with halt_n toggling at arbitrary ticks.
        for (int c = 0; c < 40; c++) begin
            if ($urandom_range(0, 3) != 0 && req_q.size() < 2)
                push(1'($urandom), 16'($urandom), 8'($urandom));
            for (int t = 0; t < CT; t++) begin
                halt_n = ($urandom_range(0, 15) != 0);
                step(1'b1);
            end
        end
        halt_n = 1'b1;
        run_cycles(4);

        // Reset asserted at tick 90 of a write cycle aborts it without a response.
        push(1'b0, 16'hD01A, 8'h3C);
        while (!(tick_abs % CT == 90 && cur.active && !cur.rw_n)) step(1'b1);
        step(1'b1);
        a8_rst_n = 1'b0;
        #1;
        check_reset_state("midwrite_rst");
        rsp_seen = 0;
        apply_reset(30);
        run_cycles(2);
        check("post_reset_rsp_count", rsp_seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
